tick_sequencer: RTL and testbench

- Run-time controller for square-wave tick generation; replaces fixed-parameter tick dividers where rate must change without re-synthesis.
- Holds an active half-period and burst length, plus a one-deep shadow config loaded by a valid/ready handshake.
- Sequences start/stop/burst operation and switches rate only on period boundaries, so every tick period is whole and glitch-free.
- Sits between a host/config master and the tick consumers (blinkers, timers, debouncers) in the same clock domain.

---
 rtl/tick_sequencer.sv | 150 +++++++++++++++
 tb/tb_tick_sequencer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sequencer.sv
// Run-time programmable tick sequencer: tick rises 1 cycle after start; config changes land only on period boundaries.
// cfg_ready is low while the one-deep shadow holds an unapplied config. Optional sticky irq under TICK_SEQ_IRQ_EN.
module tick_sequencer #(
  parameter int CNT_W        = 16,
  parameter int BURST_W      = 8,
  parameter int PCNT_W       = 16,
  parameter int DEFAULT_HALF = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [PCNT_W-1:0]  period_count
`ifdef TICK_SEQ_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clr
`endif
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     act_half;
  logic [BURST_W-1:0]   act_burst;
  logic [BURST_W-1:0]   burst_rem;
  logic [CNT_W-1:0]     sh_half;
  logic [BURST_W-1:0]   sh_burst;
  logic                 shadow_full;
  logic                 stop_pending;

  logic                 hs;
  logic                 start_go;
  logic                 period_end;
  logic                 burst_end;
  logic                 run_end;
  logic                 apply;
  logic [CNT_W-1:0]     next_half;
  logic [BURST_W-1:0]   next_burst;

  assign cfg_ready = !shadow_full;
  assign busy      = (state != IDLE);

  // A drained run finishes its LOW phase in DRAIN, recognisable by tick already low.
  always_comb begin
    hs         = cfg_valid && !shadow_full;
    start_go   = (state == IDLE) && start && !stop;
    period_end = ((state == LOW) || ((state == DRAIN) && !tick)) && (cnt == '0);
    burst_end  = (act_burst != '0) && (burst_rem == BURST_W'(1));
    run_end    = period_end && ((state == DRAIN) || burst_end || stop || stop_pending);
    apply      = shadow_full && (start_go || (period_end && !run_end));
    next_half  = apply ? sh_half  : act_half;
    next_burst = apply ? sh_burst : act_burst;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      act_half     <= CNT_W'(DEFAULT_HALF);
      act_burst    <= '0;
      burst_rem    <= '0;
      sh_half      <= '0;
      sh_burst     <= '0;
      shadow_full  <= 1'b0;
      stop_pending <= 1'b0;
      tick         <= 1'b0;
      done         <= 1'b0;
      period_count <= '0;
    end else begin
      done <= 1'b0;

      // Capture uses the pre-edge slot state, so a boundary handshake waits for the next boundary.
      if (hs) begin
        sh_half  <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        sh_burst <= cfg_burst;
      end
      shadow_full <= hs | (shadow_full & ~apply);
      if (apply) begin
        act_half  <= sh_half;
        act_burst <= sh_burst;
      end

      case (state)
        IDLE: begin
          if (start_go) begin
            cnt          <= next_half - CNT_W'(1);
            burst_rem    <= next_burst;
            stop_pending <= 1'b0;
            tick         <= 1'b1;
            state        <= HIGH;
          end
        end

        HIGH: begin
          if (cnt == '0) begin
            cnt   <= act_half - CNT_W'(1);
            tick  <= 1'b0;
            state <= stop ? DRAIN : LOW;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (stop) state <= DRAIN;
          end
        end

        LOW, DRAIN: begin
          if (period_end) begin
            period_count <= period_count + PCNT_W'(1);
            if (act_burst != '0) burst_rem <= burst_rem - BURST_W'(1);
            stop_pending <= 1'b0;
            if (run_end) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt   <= next_half - CNT_W'(1);
              tick  <= 1'b1;
              state <= HIGH;
            end
          end else if ((state == DRAIN) && (cnt == '0)) begin
            cnt  <= act_half - CNT_W'(1);
            tick <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if ((state == LOW) && stop) stop_pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef TICK_SEQ_IRQ_EN
  // Set takes priority so a clear racing the end of a run cannot lose the event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       irq <= 1'b0;
    else if (run_end) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: directed scenarios plus a randomized run against a period-level model.
module tb_tick_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_half;
  logic [7:0]  cfg_burst;
  logic        start;
  logic        stop;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] period_count;
`ifdef TICK_SEQ_IRQ_EN
  logic        irq;
  logic        irq_clr;
`endif

  int checks = 0;
  int errors = 0;

  tick_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_half     (cfg_half),
    .cfg_burst    (cfg_burst),
    .start        (start),
    .stop         (stop),
    .tick         (tick),
    .busy         (busy),
    .done         (done),
    .period_count (period_count)
`ifdef TICK_SEQ_IRQ_EN
    ,
    .irq          (irq),
    .irq_clr      (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
`ifdef TICK_SEQ_IRQ_EN
    irq_clr   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg_send(input int h, input int b);
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_half  = 16'(h);
    cfg_burst = 8'(b);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cfg_ready) ok = 1'b1;
      cyc();
    end
    cfg_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg_send: cfg_ready got %0b want 1 within 100 cycles", cfg_ready);
    end
  endtask

  task automatic stop_and_drain();
    bit seen = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) seen = 1'b1;
      else cyc();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stop_drain: done got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tick/busy/done got %0b%0b%0b want 000", tick, busy, done);
    end
    do_reset();
    checks++;
    if (period_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_period_count: got %0d want 0", period_count);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready);
    end
  endtask

  task automatic measure_1000(input string name, input int want_high, input int want_rise, input int want_pc);
    int  highs = 0;
    int  rises = 0;
    bit  prev  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tick) highs++;
      if (tick && !prev) rises++;
      prev = tick;
      cyc();
    end
    checks++;
    if (highs != want_high) begin
      errors++;
      $display("FAIL %s_high: got %0d want %0d", name, highs, want_high);
    end
    checks++;
    if (rises != want_rise) begin
      errors++;
      $display("FAIL %s_rise: got %0d want %0d", name, rises, want_rise);
    end
    checks++;
    if (period_count !== 16'(want_pc)) begin
      errors++;
      $display("FAIL %s_period_count: got %0d want %0d", name, period_count, want_pc);
    end
  endtask

  task automatic test_default_rate();
    do_reset();
    measure_1000("default_rate", 500, 20, 20);
  endtask

  task automatic test_fast_rate();
    do_reset();
    cfg_send(1, 0);
    measure_1000("half1", 500, 500, 500);
    do_reset();
    cfg_send(0, 0);
    measure_1000("half0", 500, 500, 500);
  endtask

  task automatic test_burst();
    bit exp;
    do_reset();
    cfg_send(2, 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp = ((k % 4) < 2);
      checks++;
      if (tick !== exp || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL burst_wave k=%0d: tick/busy/done got %0b%0b%0b want %0b10", k, tick, busy, done, exp);
      end
      cyc();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: done/busy/tick got %0b%0b%0b want 100", done, busy, tick);
    end
    checks++;
    if (period_count !== 16'd3) begin
      errors++;
      $display("FAIL burst_period_count: got %0d want 3", period_count);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_after: done/busy got %0b%0b want 00", done, busy);
    end
  endtask

  task automatic test_reconfig();
    bit exp_tick;
    bit exp_rdy;
    do_reset();
    cfg_send(5, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      exp_tick = (k < 10) ? (k < 5) : (((k - 10) % 4) < 2);
      exp_rdy  = !(k >= 2 && k <= 9);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL reconfig_tick k=%0d: got %0b want %0b", k, tick, exp_tick);
      end
      checks++;
      if (cfg_ready !== exp_rdy) begin
        errors++;
        $display("FAIL reconfig_ready k=%0d: got %0b want %0b", k, cfg_ready, exp_rdy);
      end
      cfg_valid = (k == 1);
      cfg_half  = 16'd2;
      cfg_burst = 8'd0;
      cyc();
    end
    cfg_valid = 1'b0;
    stop_and_drain();
  endtask

  task automatic test_stop();
    do_reset();
    cfg_send(4, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tick !== (k < 4) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stop_wave k=%0d: tick/busy/done got %0b%0b%0b want %0b10", k, tick, busy, done, (k < 4));
      end
      stop = (k == 0);
      cyc();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL stop_end: done/busy/tick got %0b%0b%0b want 100", done, busy, tick);
    end
    checks++;
    if (period_count !== 16'd1) begin
      errors++;
      $display("FAIL stop_period_count: got %0d want 1", period_count);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (tick !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL stop_idle k=%0d: tick/done got %0b%0b want 00", k, tick, done);
      end
    end
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL start_stop_idle k=%0d: busy/tick got %0b%0b want 00", k, busy, tick);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    bit ok = 1'b0;
    int highs = 0;
    bit s24 = 1'b0;
    bit s25 = 1'b1;
    do_reset();
    cfg_send(4, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (tick && period_count >= 16'd2) ok = 1'b1;
      else cyc();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL async_setup: tick/period_count got %0b/%0d want 1/>=2", tick, period_count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0 || period_count !== 16'd0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: tick/busy/pc/ready got %0b/%0b/%0d/%0b want 0/0/0/1",
               tick, busy, period_count, cfg_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tick) highs++;
      if (k == 24) s24 = tick;
      if (k == 25) s25 = tick;
      cyc();
    end
    checks++;
    if (highs != 25 || s24 !== 1'b1 || s25 !== 1'b0) begin
      errors++;
      $display("FAIL async_default_half: highs/s24/s25 got %0d/%0b/%0b want 25/1/0", highs, s24, s25);
    end
  endtask

  // Period-level model: a run is a list of periods, each fixed by the half in force at its start.
  task automatic test_random();
    int m_half, m_burst, m_bl, m_ps, m_pc, sh_h, sh_b, h0, b0;
    bit m_run, m_sf, m_done, hs, exp_tick;
    do_reset();
    h0 = $urandom_range(0, 5);
    b0 = $urandom_range(1, 3);
    cfg_send(h0, b0);
    m_half = 25; m_burst = 0; m_bl = 0; m_ps = 0; m_pc = 0;
    m_run = 1'b0; m_sf = 1'b1;
    sh_h = (h0 == 0) ? 1 : h0;
    sh_b = b0;
    for (int t = 0; t < 1500; t++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_half  = 16'($urandom_range(0, 5));
      cfg_burst = 8'($urandom_range(1, 3));
      start     = ($urandom_range(0, 5) == 0);
      hs = cfg_valid && !m_sf;
      cyc();
      m_done = 1'b0;
      if (!m_run) begin
        if (start) begin
          if (m_sf) begin m_half = sh_h; m_burst = sh_b; m_sf = 1'b0; end
          m_run = 1'b1; m_ps = t; m_bl = m_burst;
        end
      end else if (t == m_ps + 2 * m_half) begin
        m_pc++;
        if (m_burst != 0) m_bl--;
        if (m_burst != 0 && m_bl == 0) begin
          m_run = 1'b0; m_done = 1'b1;
        end else begin
          if (m_sf) begin m_half = sh_h; m_burst = sh_b; m_sf = 1'b0; end
          m_ps = t;
        end
      end
      if (hs) begin
        sh_h = (cfg_half == 16'd0) ? 1 : int'(cfg_half);
        sh_b = int'(cfg_burst);
        m_sf = 1'b1;
      end
      exp_tick = m_run && ((t - m_ps) < m_half);
      checks++;
      if (tick !== exp_tick || busy !== m_run || done !== m_done) begin
        errors++;
        $display("FAIL random_out t=%0d: tick/busy/done got %0b%0b%0b want %0b%0b%0b",
                 t, tick, busy, done, exp_tick, m_run, m_done);
      end
      checks++;
      if (cfg_ready !== !m_sf || period_count !== 16'(m_pc)) begin
        errors++;
        $display("FAIL random_state t=%0d: ready/pc got %0b/%0d want %0b/%0d",
                 t, cfg_ready, period_count, !m_sf, 16'(m_pc));
      end
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

`ifdef TICK_SEQ_IRQ_EN
  task automatic test_irq();
    do_reset();
    cfg_send(1, 1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %0b want 0", irq); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    checks++;
    if (done !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: done/irq got %0b%0b want 11", done, irq);
    end
    repeat (3) cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %0b want 1", irq); end
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %0b want 0", irq); end
    start = 1'b1;
    cyc();
    start   = 1'b0;
    irq_clr = 1'b1;
    cyc();
    cyc();
    irq_clr = 1'b0;
    checks++;
    if (done !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: done/irq got %0b%0b want 11", done, irq);
    end
    cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %0b want 1", irq); end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
`ifdef TICK_SEQ_IRQ_EN
    irq_clr   = 1'b0;
`endif
    test_reset();
    test_default_rate();
    test_fast_rate();
    test_burst();
    test_reconfig();
    test_stop();
    test_async_reset();
    test_random();
`ifdef TICK_SEQ_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
